// File: rtl/mult_sequencer_if.sv
// Pipeline <-> multiply sequencer bundle: operand capture, shared-ALU request/grant, HI/LO results.
// master = pipeline/ALU side, slave = sequencer side.
interface mult_sequencer_if;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  aluop;
    logic [31:0] alu_out;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, is_signed, op_a, op_b, alu_gnt, alu_out,
        input  alu_req, alu_a, alu_b, aluop, busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, alu_gnt, alu_out,
        output alu_req, alu_a, alu_b, aluop, busy, done, hi, lo
    );
endinterface

// File: rtl/mult_sequencer.sv
// 32x32->64 MULT/MULTU shift-and-add sequencer on the borrowed ALU; done 2 cycles after the 32nd grant (34 cycles unstalled).
// Withheld alu_gnt freezes every register for as long as it lasts; start is only accepted in IDLE.
module mult_sequencer (
    input  logic          CLK,
    input  logic          RST,
    mult_sequencer_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic        r_neg;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_alu_b;
    logic        w_carry;
    logic [63:0] w_neg_prod;
    logic        w_alu_req;
    logic        w_busy;
    logic        w_done;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_abs_a = (bus.is_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
    assign w_abs_b = (bus.is_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;

    assign w_alu_b    = r_lo[0] ? r_mcand : 32'd0;
    assign w_carry    = (r_hi[31] & w_alu_b[31]) | ((r_hi[31] | w_alu_b[31]) & ~bus.alu_out[31]);
    assign w_neg_prod = ~{r_hi, r_lo} + 64'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_alu_req = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = ITER;
                end
            end
            ITER: begin
                w_alu_req = 1'b1;
                w_busy    = 1'b1;
                if (bus.alu_gnt && (r_cnt == 5'd31)) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_busy = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mcand <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_cnt   <= 5'd0;
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mcand <= w_abs_a;
                        r_lo    <= w_abs_b;
                        r_hi    <= 32'd0;
                        r_cnt   <= 5'd0;
                        r_neg   <= bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
                    end
                end
                ITER: begin
                    // Shift the 33-bit sum right into HI and the consumed multiplier bit out of LO.
                    if (bus.alu_gnt) begin
                        {r_hi, r_lo} <= {w_carry, bus.alu_out, r_lo[31:1]};
                        r_cnt        <= r_cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (r_neg) begin
                        {r_hi, r_lo} <= w_neg_prod;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.alu_req = w_alu_req;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.alu_a   = r_hi;
    assign bus.alu_b   = w_alu_b;
    assign bus.aluop   = ALU_ADD;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
endmodule
